dmem_arbiter: RTL

Two-requester arbiter sharing the single-port data memory of the RISC_V_Processor between the core load/store path (requester 0) and a debug/loader port (requester 1). The debug port preloads and inspects data memory, e.g. the words surfaced on Index_0..Index_4, without halting the core. The block issues at most one memory access per cycle and routes read data back to the originator after a fixed memory latency. Core has priority; a burst limit guarantees the debug port cannot starve.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_rdpipe.sv | 33 +++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CORE,
    ARB_DBG
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  localparam int unsigned STAT_W  = 32;
  localparam int unsigned BURST_W = 4;

endpackage

// File: rtl/dmem_arb_rdpipe.sv
// MEM_LAT-deep {valid, id} shift register tracking reads in flight; async clear drops them.
module dmem_arb_rdpipe #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push_valid,
  input  logic push_id,
  output logic pop_valid,
  output logic pop_id
);

  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] id_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= push_valid;
      id_q[0]  <= push_id;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign pop_valid = vld_q[MEM_LAT-1];
  assign pop_id    = id_q[MEM_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the single-port data memory with a debug anti-starvation burst limit.
// Define DMEM_ARB_STATS_EN to build the grant/wait statistics counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [STAT_W-1:0] stat_core,
  output logic [STAT_W-1:0] stat_dbg,
  output logic [STAT_W-1:0] stat_wait
);

  localparam logic [BURST_W-1:0] BurstMax = BURST_W'(MAX_BURST);

  arb_state_e         state_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic               dbg_turn;
  logic               rd_push;
  logic               rd_valid;
  logic               rd_id;

  assign dbg_turn = (burst_cnt_q == BurstMax);

  // Grants are masked during reset so no access escapes while requests are held.
  assign c_gnt = reset && c_req && !(d_req && dbg_turn);
  assign d_gnt = reset && d_req && (!c_req || dbg_turn);
  assign m_en  = c_gnt | d_gnt;

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      burst_cnt_q <= '0;
    end else begin
      if (c_gnt) begin
        state_q <= ARB_CORE;
      end else if (d_gnt) begin
        state_q <= ARB_DBG;
      end else begin
        state_q <= ARB_IDLE;
      end

      if (d_gnt || !d_req) begin
        burst_cnt_q <= '0;
      end else if (c_gnt && !dbg_turn) begin
        burst_cnt_q <= burst_cnt_q + 1'b1;
      end
    end
  end

  // A burst can only be open while the core owned the previous cycle.
  burst_only_after_core: assert property (@(posedge clk) disable iff (!reset)
    (state_q != ARB_CORE) |-> (burst_cnt_q == '0));

  assign rd_push = (c_gnt && !c_we) || (d_gnt && !d_we);

  dmem_arb_rdpipe #(
    .MEM_LAT(MEM_LAT)
  ) u_rdpipe (
    .clk       (clk),
    .reset     (reset),
    .push_valid(rd_push),
    .push_id   (d_gnt ? REQ_DBG : REQ_CORE),
    .pop_valid (rd_valid),
    .pop_id    (rd_id)
  );

  assign c_rvalid = rd_valid && (rd_id == REQ_CORE);
  assign d_rvalid = rd_valid && (rd_id == REQ_DBG);
  assign c_rdata  = c_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_core_q;
  logic [STAT_W-1:0] stat_dbg_q;
  logic [STAT_W-1:0] stat_wait_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_core_q <= '0;
      stat_dbg_q  <= '0;
      stat_wait_q <= '0;
    end else begin
      if (c_gnt && (stat_core_q != '1)) stat_core_q <= stat_core_q + 1'b1;
      if (d_gnt && (stat_dbg_q != '1)) stat_dbg_q <= stat_dbg_q + 1'b1;
      if (d_req && !d_gnt && (stat_wait_q != '1)) stat_wait_q <= stat_wait_q + 1'b1;
    end
  end

  assign stat_core = stat_core_q;
  assign stat_dbg  = stat_dbg_q;
  assign stat_wait = stat_wait_q;
`else
  assign stat_core = '0;
  assign stat_dbg  = '0;
  assign stat_wait = '0;
`endif

endmodule
